mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_pkg.sv | 18 +
 rtl/mult_div_if.sv | 26 ++
 rtl/div_step.sv | 29 ++
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the signed multiply/divide unit: state encoding and default width.
package mult_div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StMult = MULT,
    StDiv  = DIV,
    StDone = DONE
  } stateT;

endpackage

// File: rtl/mult_div_if.sv
// Operation request / result bundle between a requester (master) and the mult/div unit (slave).
interface mult_div_if import mult_div_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             MultCtrl;
  logic             DivCtrl;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic [WIDTH-1:0] HIOut;
  logic [WIDTH-1:0] LOOut;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (
    output MultCtrl, DivCtrl, OpA, OpB,
    input  HIOut, LOOut, Busy, Done, DivZero
  );

  modport slave (
    input  MultCtrl, DivCtrl, OpA, OpB,
    output HIOut, LOOut, Busy, Done, DivZero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next dividend bit,
// subtract the divisor if it fits, and shift the resulting quotient bit in.
module div_step import mult_div_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] remI,
  input  logic [WIDTH-1:0] quotI,
  input  logic [WIDTH-1:0] divisorI,
  output logic [WIDTH-1:0] remO,
  output logic [WIDTH-1:0] quotO
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;

  always_comb begin
    shifted = {remI, quotI[WIDTH-1]};
    // The difference is below the divisor whenever it is kept, so WIDTH bits suffice.
    trial   = shifted[WIDTH-1:0] - divisorI;
    if (shifted >= {1'b0, divisorI}) begin
      remO  = trial;
      quotO = {quotI[WIDTH-2:0], 1'b1};
    end else begin
      remO  = shifted[WIDTH-1:0];
      quotO = {quotI[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (Booth radix-2) and signed restoring divide with a shared
// shift datapath; results are published to HIOut/LOOut only when an operation completes.
module mult_div_unit import mult_div_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned ITER  = WIDTH
) (
  input logic      clock,
  input logic      reset,
  mult_div_if.slave bus
);

  localparam int unsigned CntW = $clog2(ITER + 1);

  stateT            stateQ, stateD;
  logic [CntW-1:0]  cntQ, cntD;
  // hiQ: Booth accumulator (one guard bit) or division remainder.
  // loQ: multiplier being shifted out, or dividend shifting into quotient.
  // opQ: sign-extended multiplicand, or divisor magnitude.
  logic [WIDTH:0]   hiQ, hiD;
  logic [WIDTH-1:0] loQ, loD;
  logic [WIDTH:0]   opQ, opD;
  logic             qm1Q, qm1D;
  logic             negQuotQ, negQuotD;
  logic             negRemQ, negRemD;
  logic [WIDTH-1:0] hiOutQ, hiOutD;
  logic [WIDTH-1:0] loOutQ, loOutD;
  logic             divZeroQ, divZeroD;

  logic [WIDTH:0]   boothSum;
  logic [WIDTH:0]   boothHi;
  logic [WIDTH-1:0] boothLo;
  logic [WIDTH-1:0] stepRem, stepQuot;
  logic [WIDTH-1:0] absA, absB;
  logic             lastIter;

  always_comb begin
    unique case ({loQ[0], qm1Q})
      2'b01:   boothSum = hiQ + opQ;
      2'b10:   boothSum = hiQ - opQ;
      default: boothSum = hiQ;
    endcase
    boothHi = {boothSum[WIDTH], boothSum[WIDTH:1]};
    boothLo = {boothSum[0], loQ[WIDTH-1:1]};
  end

  div_step #(
    .WIDTH(WIDTH)
  ) uDivStep (
    .remI    (hiQ[WIDTH-1:0]),
    .quotI   (loQ),
    .divisorI(opQ[WIDTH-1:0]),
    .remO    (stepRem),
    .quotO   (stepQuot)
  );

  assign absA     = bus.OpA[WIDTH-1] ? -bus.OpA : bus.OpA;
  assign absB     = bus.OpB[WIDTH-1] ? -bus.OpB : bus.OpB;
  assign lastIter = (cntQ == CntW'(1));

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    hiD      = hiQ;
    loD      = loQ;
    opD      = opQ;
    qm1D     = qm1Q;
    negQuotD = negQuotQ;
    negRemD  = negRemQ;
    hiOutD   = hiOutQ;
    loOutD   = loOutQ;
    divZeroD = divZeroQ;

    unique case (stateQ)
      StIdle: begin
        if (bus.MultCtrl) begin
          stateD   = StMult;
          cntD     = CntW'(ITER);
          hiD      = '0;
          loD      = bus.OpB;
          opD      = {bus.OpA[WIDTH-1], bus.OpA};
          qm1D     = 1'b0;
          divZeroD = 1'b0;
        end else if (bus.DivCtrl) begin
          if (bus.OpB == '0) begin
            stateD   = StDone;
            divZeroD = 1'b1;
          end else begin
            stateD   = StDiv;
            cntD     = CntW'(ITER);
            hiD      = '0;
            loD      = absA;
            opD      = {1'b0, absB};
            negQuotD = bus.OpA[WIDTH-1] ^ bus.OpB[WIDTH-1];
            negRemD  = bus.OpA[WIDTH-1];
            divZeroD = 1'b0;
          end
        end
      end
      StMult: begin
        hiD  = boothHi;
        loD  = boothLo;
        qm1D = loQ[0];
        cntD = cntQ - CntW'(1);
        if (lastIter) begin
          stateD = StDone;
          hiOutD = boothHi[WIDTH-1:0];
          loOutD = boothLo;
        end
      end
      StDiv: begin
        hiD  = {1'b0, stepRem};
        loD  = stepQuot;
        cntD = cntQ - CntW'(1);
        if (lastIter) begin
          stateD = StDone;
          hiOutD = negRemQ  ? -stepRem  : stepRem;
          loOutD = negQuotQ ? -stepQuot : stepQuot;
        end
      end
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ   <= StIdle;
      cntQ     <= '0;
      hiQ      <= '0;
      loQ      <= '0;
      opQ      <= '0;
      qm1Q     <= 1'b0;
      negQuotQ <= 1'b0;
      negRemQ  <= 1'b0;
      hiOutQ   <= '0;
      loOutQ   <= '0;
      divZeroQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      hiQ      <= hiD;
      loQ      <= loD;
      opQ      <= opD;
      qm1Q     <= qm1D;
      negQuotQ <= negQuotD;
      negRemQ  <= negRemD;
      hiOutQ   <= hiOutD;
      loOutQ   <= loOutD;
      divZeroQ <= divZeroD;
    end
  end

  assign bus.HIOut   = hiOutQ;
  assign bus.LOOut   = loOutQ;
  assign bus.DivZero = divZeroQ;
  assign bus.Busy    = (stateQ == StMult) || (stateQ == StDiv);
  assign bus.Done    = (stateQ == StDone);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes model results, a monitor checks each Done.
module tb_mult_div_unit;

  localparam int unsigned W    = 32;
  localparam int unsigned ITER = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           doneCyc;
  } expT;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  expT  sbQ[$];

  logic [W-1:0] lastHi;
  logic [W-1:0] lastLo;

  mult_div_if #(.WIDTH(W)) bus ();

  mult_div_unit #(
    .WIDTH(W),
    .ITER (ITER)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain signed arithmetic on 64-bit integers.
  task automatic pushExpected(input bit m, input bit d, input logic [W-1:0] a,
                              input logic [W-1:0] b, input int startCyc);
    expT    e;
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m) begin
      p       = sa * sb;
      e.hi    = p[63:32];
      e.lo    = p[31:0];
      e.dz    = 1'b0;
      e.doneCyc = startCyc + ITER + 1;
    end else if (b == '0) begin
      e.hi    = lastHi;
      e.lo    = lastLo;
      e.dz    = 1'b1;
      e.doneCyc = startCyc + 1;
    end else begin
      q       = sa / sb;
      r       = sa % sb;
      e.hi    = r[31:0];
      e.lo    = q[31:0];
      e.dz    = 1'b0;
      e.doneCyc = startCyc + ITER + 1;
    end
    lastHi = e.hi;
    lastLo = e.lo;
    sbQ.push_back(e);
  endtask

  always @(posedge clock) begin
    expT e;
    #1;
    if (!reset && bus.Done) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1, expected no Done (cycle %0d)", cyc);
      end else begin
        e = sbQ.pop_front();
        check("hi_out", 64'(bus.HIOut), 64'(e.hi));
        check("lo_out", 64'(bus.LOOut), 64'(e.lo));
        check("div_zero", 64'(bus.DivZero), 64'(e.dz));
        check("done_cycle", 64'(cyc), 64'(e.doneCyc));
        check("busy_at_done", 64'(bus.Busy), 64'(0));
      end
    end
  end

  task automatic startOp(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    bus.MultCtrl = m;
    bus.DivCtrl  = d;
    bus.OpA      = a;
    bus.OpB      = b;
    pushExpected(m, d, a, b, cyc);
    @(negedge clock);
    bus.MultCtrl = 1'b0;
    bus.DivCtrl  = 1'b0;
    bus.OpA      = $urandom;
    bus.OpB      = $urandom;
    if (m || b != '0) check("busy_after_start", 64'(bus.Busy), 64'(1));
  endtask

  task automatic waitDone();
    int n = 0;
    while (!bus.Done && n < int'(ITER) + 8) begin
      @(negedge clock);
      n++;
    end
    if (!bus.Done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no Done after %0d cycles, expected Done", n);
    end
    @(negedge clock);
  endtask

  task automatic doOp(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
    startOp(m, d, a, b);
    waitDone();
  endtask

  initial begin
    logic [W-1:0] a, b, prevHi, prevLo;
    int kind;
    checks = 0;
    errors = 0;
    lastHi = '0;
    lastLo = '0;
    bus.MultCtrl = 1'b0;
    bus.DivCtrl  = 1'b0;
    bus.OpA      = '0;
    bus.OpB      = '0;
    reset = 1'b1;
    #1;
    check("reset_hi", 64'(bus.HIOut), 64'(0));
    check("reset_lo", 64'(bus.LOOut), 64'(0));
    check("reset_busy", 64'(bus.Busy), 64'(0));
    check("reset_done", 64'(bus.Done), 64'(0));
    check("reset_divzero", 64'(bus.DivZero), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;

    doOp(1'b1, 1'b0, 32'd7, -32'sd3);
    doOp(1'b0, 1'b1, 32'd100, 32'd7);
    doOp(1'b0, 1'b1, -32'sd100, 32'd7);
    doOp(1'b0, 1'b1, 32'h1234_5678, 32'd0);
    repeat (3) @(negedge clock);
    check("divzero_held", 64'(bus.DivZero), 64'(1));
    doOp(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    doOp(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    doOp(1'b1, 1'b1, 32'd12345, -32'sd678);

    // DivCtrl with new operands while a multiply runs must not disturb it.
    startOp(1'b1, 1'b0, -32'sd99, 32'd1001);
    repeat (5) @(negedge clock);
    bus.DivCtrl = 1'b1;
    bus.OpA     = 32'd5;
    bus.OpB     = 32'd0;
    @(negedge clock);
    bus.DivCtrl = 1'b0;
    waitDone();
    repeat (4) @(negedge clock);

    // Reset ten iterations into a multiply: outputs clear and no Done follows.
    prevHi = lastHi;
    prevLo = lastLo;
    startOp(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (10) @(negedge clock);
    check("midop_hi_stable", 64'(bus.HIOut), 64'(prevHi));
    check("midop_lo_stable", 64'(bus.LOOut), 64'(prevLo));
    reset = 1'b1;
    sbQ.delete();
    lastHi = '0;
    lastLo = '0;
    #1;
    check("abort_hi", 64'(bus.HIOut), 64'(0));
    check("abort_lo", 64'(bus.LOOut), 64'(0));
    check("abort_busy", 64'(bus.Busy), 64'(0));
    check("abort_done", 64'(bus.Done), 64'(0));
    check("abort_divzero", 64'(bus.DivZero), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    repeat (ITER + 4) @(negedge clock);
    doOp(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D);

    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 9);
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : 32'($urandom);
      if ($urandom_range(0, 4) == 0) a = -32'($urandom_range(0, 300));
      if (kind == 9) b = '0;
      else if (b == '0) b = 32'd3;
      doOp(kind < 5, kind >= 5, a, b);
    end

    repeat (4) @(negedge clock);
    check("scoreboard_drained", 64'(sbQ.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
